pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage CPU pipeline. It generates the stall, flush and hold controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken branches, multi-cycle memory waits and the HLT drain/freeze sequence. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline. Controls are combinational and take effect on the same edge.
// Memory waits freeze everything upstream of MEM/WB. A HLT drains the pipeline and then freezes it until resume.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ID_hlt,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_use_rs,
    input  logic        ID_use_rt,
    input  logic        EX_mem_read,
    input  logic        EX_use_dst_reg,
    input  logic [4:0]  EX_dst_reg,
    input  logic        EX_branch_taken,
    input  logic        MEM_mem_req,
    input  logic        MEM_mem_ready,
    input  logic        resume,
    output logic        PC_hold,
    output logic        IF_ID_stall,
    output logic        ID_EX_stall,
    output logic        EX_MEM_stall,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        EX_MEM_flush,
    output logic        MEM_WB_flush,
    output logic        MEM_WB_hlt,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    state_t     ret_state;
    state_t     ret_nxt;
    state_t     adv_state;
    logic [1:0] drain_cnt;
    logic [1:0] drain_nxt;
    logic       mem_wait;
    logic       rs_hit;
    logic       rt_hit;
    logic       load_use;

    assign mem_wait = MEM_mem_req & ~MEM_mem_ready;
    assign rs_hit   = ID_use_rs & (ID_rs == EX_dst_reg);
    assign rt_hit   = ID_use_rt & (ID_rt == EX_dst_reg);
    assign load_use = EX_mem_read & EX_use_dst_reg & (EX_dst_reg != 5'd0) & (rs_hit | rt_hit);

    // The cycle that releases MEM_WAIT is an ordinary advance of the interrupted state.
    assign adv_state = (state == MEM_WAIT) ? ret_state : state;

    always_comb begin
        PC_hold      = 1'b0;
        IF_ID_stall  = 1'b0;
        ID_EX_stall  = 1'b0;
        EX_MEM_stall = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        MEM_WB_flush = 1'b0;
        MEM_WB_hlt   = 1'b0;
        state_nxt    = state;
        ret_nxt      = ret_state;
        drain_nxt    = drain_cnt;

        if (!rst_n) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            MEM_WB_flush = 1'b1;
        end else if (state == HALTED) begin
            PC_hold      = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_stall  = 1'b1;
            EX_MEM_stall = 1'b1;
            MEM_WB_hlt   = 1'b1;
            if (resume) begin
                state_nxt = RUN;
            end
        end else if (mem_wait) begin
            // Bubble into WB so the stalled MEM instruction is not written back twice.
            PC_hold      = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_stall  = 1'b1;
            EX_MEM_stall = 1'b1;
            MEM_WB_flush = 1'b1;
            state_nxt    = MEM_WAIT;
            if (state != MEM_WAIT) begin
                ret_nxt = state;
            end
        end else if (EX_branch_taken) begin
            // Squashes younger instructions, including a HLT being drained.
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            state_nxt   = RUN;
            ret_nxt     = RUN;
            drain_nxt   = 2'd0;
        end else if (adv_state == DRAIN) begin
            PC_hold     = 1'b1;
            IF_ID_flush = 1'b1;
            drain_nxt   = drain_cnt - 2'd1;
            state_nxt   = (drain_cnt == 2'd1) ? HALTED : DRAIN;
            ret_nxt     = RUN;
        end else if (load_use) begin
            PC_hold     = 1'b1;
            IF_ID_stall = 1'b1;
            ID_EX_flush = 1'b1;
            state_nxt   = RUN;
        end else if (ID_hlt) begin
            PC_hold     = 1'b1;
            IF_ID_flush = 1'b1;
            state_nxt   = DRAIN;
            drain_nxt   = 2'd3;
        end else begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            ret_state    <= RUN;
            drain_cnt    <= 2'd0;
            halted       <= 1'b0;
            stall_cycles <= 16'd0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            drain_cnt <= drain_nxt;
            halted    <= (state_nxt == HALTED);
            if (PC_hold && (state != HALTED) && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed checks of pipeline_ctrl against a drain-counter/halt-flag reference model.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ID_hlt;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        ID_use_rs;
    logic        ID_use_rt;
    logic        EX_mem_read;
    logic        EX_use_dst_reg;
    logic [4:0]  EX_dst_reg;
    logic        EX_branch_taken;
    logic        MEM_mem_req;
    logic        MEM_mem_ready;
    logic        resume;
    logic        PC_hold;
    logic        IF_ID_stall;
    logic        ID_EX_stall;
    logic        EX_MEM_stall;
    logic        IF_ID_flush;
    logic        ID_EX_flush;
    logic        EX_MEM_flush;
    logic        MEM_WB_flush;
    logic        MEM_WB_hlt;
    logic        halted;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    // Reference model: a frozen-pipeline flag, cycles of drain left, and the debug count.
    bit m_halted;
    int m_drain;
    int m_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ID_hlt          (ID_hlt),
        .ID_rs           (ID_rs),
        .ID_rt           (ID_rt),
        .ID_use_rs       (ID_use_rs),
        .ID_use_rt       (ID_use_rt),
        .EX_mem_read     (EX_mem_read),
        .EX_use_dst_reg  (EX_use_dst_reg),
        .EX_dst_reg      (EX_dst_reg),
        .EX_branch_taken (EX_branch_taken),
        .MEM_mem_req     (MEM_mem_req),
        .MEM_mem_ready   (MEM_mem_ready),
        .resume          (resume),
        .PC_hold         (PC_hold),
        .IF_ID_stall     (IF_ID_stall),
        .ID_EX_stall     (ID_EX_stall),
        .EX_MEM_stall    (EX_MEM_stall),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_flush     (ID_EX_flush),
        .EX_MEM_flush    (EX_MEM_flush),
        .MEM_WB_flush    (MEM_WB_flush),
        .MEM_WB_hlt      (MEM_WB_hlt),
        .halted          (halted),
        .stall_cycles    (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst_n           = 1'b1;
        ID_hlt          = 1'b0;
        ID_rs           = 5'd0;
        ID_rt           = 5'd0;
        ID_use_rs       = 1'b0;
        ID_use_rt       = 1'b0;
        EX_mem_read     = 1'b0;
        EX_use_dst_reg  = 1'b0;
        EX_dst_reg      = 5'd0;
        EX_branch_taken = 1'b0;
        MEM_mem_req     = 1'b0;
        MEM_mem_ready   = 1'b0;
        resume          = 1'b0;
    endtask

    // Called at a falling edge with inputs already applied; checks, advances the model, returns at the next falling edge.
    task automatic cycle(input string tag);
        bit lu, mw;
        bit p, s1, s2, s3, f1, f2, f3, f4, h;
        {p, s1, s2, s3, f1, f2, f3, f4, h} = 9'd0;
        #1;
        lu = EX_mem_read && EX_use_dst_reg && (EX_dst_reg != 5'd0) &&
             ((ID_use_rs && ID_rs == EX_dst_reg) || (ID_use_rt && ID_rt == EX_dst_reg));
        mw = MEM_mem_req && !MEM_mem_ready;

        if (!rst_n)               {f1, f2, f3, f4} = 4'hF;
        else if (m_halted)        {p, s1, s2, s3, h} = 5'h1F;
        else if (mw)              {p, s1, s2, s3, f4} = 5'h1F;
        else if (EX_branch_taken) {f1, f2} = 2'b11;
        else if (m_drain > 0)     {p, f1} = 2'b11;
        else if (lu)              {p, s1, f2} = 3'b111;
        else if (ID_hlt)          {p, f1} = 2'b11;

        chk($sformatf("%s.ctrl", tag),
            {23'd0, PC_hold, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
             IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, MEM_WB_hlt},
            {23'd0, p, s1, s2, s3, f1, f2, f3, f4, h});
        chk($sformatf("%s.halted", tag), {31'd0, halted}, {31'd0, m_halted});
        chk($sformatf("%s.stall_cycles", tag), {16'd0, stall_cycles}, m_cnt);

        if (!rst_n) begin
            m_halted = 1'b0;
            m_drain  = 0;
            m_cnt    = 0;
        end else if (m_halted) begin
            if (resume) m_halted = 1'b0;
        end else begin
            if (p && m_cnt < 65535) m_cnt++;
            if (!mw) begin
                if (EX_branch_taken) begin
                    m_drain = 0;
                end else if (m_drain > 0) begin
                    m_drain--;
                    if (m_drain == 0) m_halted = 1'b1;
                end else if (!lu && ID_hlt) begin
                    m_drain = 3;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic set_load_use();
        EX_mem_read    = 1'b1;
        EX_use_dst_reg = 1'b1;
        EX_dst_reg     = 5'd5;
        ID_rs          = 5'd5;
        ID_use_rs      = 1'b1;
    endtask

    initial begin
        int n;
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        m_halted = 1'b0;
        m_drain  = 0;
        m_cnt    = 0;
        cycle("reset");
        idle();
        cycle("idle");

        // Load-use costs one bubble.
        set_load_use();
        cycle("lu");
        idle();
        cycle("lu_after");
        chk("lu_cnt", {16'd0, stall_cycles}, 1);

        // Taken branch overrides a simultaneous load-use.
        set_load_use();
        EX_branch_taken = 1'b1;
        cycle("br_lu");
        idle();
        cycle("br_lu_after");
        chk("br_lu_cnt", {16'd0, stall_cycles}, 1);

        // Three wait cycles then the ready cycle.
        for (int i = 0; i < 3; i++) begin
            idle();
            MEM_mem_req = 1'b1;
            cycle("mw");
        end
        MEM_mem_ready = 1'b1;
        cycle("mw_ready");
        idle();
        cycle("mw_after");

        // HLT with a 2-cycle memory wait in the middle of the drain.
        ID_hlt = 1'b1;
        cycle("hlt");
        n = 1;
        while (halted !== 1'b1 && n < 20) begin
            idle();
            MEM_mem_req = (n == 2 || n == 3);
            cycle("hlt_drain");
            n++;
        end
        chk("hlt_edges", n, 6);

        for (int i = 0; i < 4; i++) begin
            idle();
            ID_hlt          = 1'($urandom_range(1));
            EX_branch_taken = 1'($urandom_range(1));
            MEM_mem_req     = 1'($urandom_range(1));
            set_load_use();
            cycle("halted_hold");
        end

        // resume and ID_hlt together: resume wins, HLT re-evaluated next cycle.
        idle();
        resume = 1'b1;
        ID_hlt = 1'b1;
        cycle("resume_hlt");
        idle();
        ID_hlt = 1'b1;
        cycle("hlt_again");
        idle();
        EX_branch_taken = 1'b1;
        cycle("br_in_drain");
        idle();
        for (int i = 0; i < 6; i++) cycle("post_br");
        chk("br_drain_no_halt", {31'd0, halted}, 0);

        // Reset while HALTED.
        ID_hlt = 1'b1;
        cycle("hlt2");
        idle();
        for (int i = 0; i < 4; i++) cycle("drain2");
        rst_n = 1'b0;
        cycle("rst_halted");
        idle();
        cycle("after_rst_halted");

        // Reset while in MEM_WAIT.
        MEM_mem_req = 1'b1;
        cycle("mw2");
        rst_n = 1'b0;
        cycle("rst_mw");
        idle();
        cycle("after_rst_mw");

        for (int i = 0; i < 3000; i++) begin
            rst_n           = ($urandom_range(99) != 0);
            ID_hlt          = ($urandom_range(9) == 0);
            ID_rs           = 5'($urandom_range(3));
            ID_rt           = 5'($urandom_range(3));
            ID_use_rs       = 1'($urandom_range(1));
            ID_use_rt       = 1'($urandom_range(1));
            EX_mem_read     = 1'($urandom_range(1));
            EX_use_dst_reg  = 1'($urandom_range(1));
            EX_dst_reg      = 5'($urandom_range(3));
            EX_branch_taken = ($urandom_range(9) == 0);
            MEM_mem_req     = ($urandom_range(3) == 0);
            MEM_mem_ready   = 1'($urandom_range(1));
            resume          = ($urandom_range(7) == 0);
            cycle("rand");
        end

        // Saturation of the stall counter, then clear by reset.
        idle();
        rst_n = 1'b0;
        cycle("sat_rst");
        idle();
        MEM_mem_req = 1'b1;
        for (int i = 0; i < 65540; i++) cycle("sat");
        chk("sat_value", {16'd0, stall_cycles}, 32'hFFFF);
        rst_n = 1'b0;
        cycle("sat_clear");
        idle();
        cycle("sat_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
